// File: rtl/serial_argmax_pkg.sv
// serial_argmax_pkg: default sizing shared by the argmax block and its users.
//   DEF_WIDTH        default signed sample width
//   DEF_ARGMAX_WIDTH default index/argmax width
package serial_argmax_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_ARGMAX_WIDTH = 5;
endpackage

// File: rtl/serial_argmax_counter.sv
// serial_argmax_counter: wrapping up-counter that supplies the index of the next sample.
//   clk   rising-edge clock
//   rst   asynchronous active-low reset, clears count to 0
//   en    advance by one on this edge
//   count index of the next sample, wraps modulo 2^W
module serial_argmax_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q, count_d;
  always_comb count_d = en ? count_q + W'(1) : count_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  assign count = count_q;
endmodule

// File: rtl/serial_argmax.sv
// serial_argmax: streaming argmax, reports the index of the largest signed sample since reset.
//   clk     rising-edge clock
//   rst     asynchronous active-low reset
//   enable  accept in on this edge
//   in      signed two's complement sample
//   argmax  registered index of the earliest maximum seen
module serial_argmax
  import serial_argmax_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ARGMAX_WIDTH = DEF_ARGMAX_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic signed [WIDTH-1:0] in,
  output logic [ARGMAX_WIDTH-1:0] argmax
);
  localparam logic signed [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  logic [ARGMAX_WIDTH-1:0] idx, argmax_q, argmax_d;
  logic signed [WIDTH-1:0] max_val_q, max_val_d;
  logic first_q, first_d, take;
  serial_argmax_counter #(.W(ARGMAX_WIDTH)) u_idx (
    .clk(clk), .rst(rst), .en(enable), .count(idx)
  );
  // first forces capture so an all-minimum stream still reports index 0;
  // strict compare keeps the earliest of equal maxima
  always_comb begin
    take = enable && (first_q || (in > max_val_q));
    max_val_d = take ? in : max_val_q;
    argmax_d = take ? idx : argmax_q;
    first_d = enable ? 1'b0 : first_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      max_val_q <= MIN_VAL;
      argmax_q <= '0;
      first_q <= 1'b1;
    end else begin
      max_val_q <= max_val_d;
      argmax_q <= argmax_d;
      first_q <= first_d;
    end
  assign argmax = argmax_q;
endmodule

// File: tb/tb_serial_argmax.sv
// tb_serial_argmax: directed vectors, async reset corners and random stream vs reference model.
module tb_serial_argmax;
  logic clk = 1'b0, rst = 1'b0, enable = 1'b0;
  logic signed [3:0] din = '0;
  logic [4:0] argmax;
  int checks = 0, failures = 0;
  typedef struct {
    bit rst_pre;
    bit en;
    logic signed [3:0] val;
    logic [4:0] exp;
    string name;
  } vec_t;
  vec_t vecs[$];
  int samples[$];

  serial_argmax #(.WIDTH(4), .ARGMAX_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .enable(enable), .in(din), .argmax(argmax)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: argmax=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input bit r, input bit e, input int v, input int x, input string nm);
    vec_t t;
    t.rst_pre = r; t.en = e; t.val = 4'(v); t.exp = 5'(x); t.name = nm;
    vecs.push_back(t);
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    enable = 1'b0;
    rst = 1'b0;
    #2 check({nm, "_rst"}, argmax, 5'd0);
    @(negedge clk);
    rst = 1'b1;
    samples.delete();
  endtask

  task automatic step(input bit e, input logic signed [3:0] v);
    @(negedge clk);
    enable = e;
    din = v;
    @(posedge clk);
    #1;
    enable = 1'b0;
  endtask

  function automatic logic [4:0] model();
    int best = 0;
    for (int i = 1; i < samples.size(); i++)
      if (samples[i] > samples[best]) best = i;
    return 5'(best);
  endfunction

  initial begin
    // reset held low: clocks and enabled samples must not move argmax
    rst = 1'b0; enable = 1'b1; din = 4'sd5;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("hold_rst", argmax, 5'd0);
    end
    @(negedge clk); rst = 1'b1; enable = 1'b0;

    for (int k = 0; k < 16; k++) add(k == 0, 1, k - 8, k, "ramp");
    add(1, 1, 1, 0, "peak"); add(0, 1, 3, 1, "peak"); add(0, 1, 7, 2, "peak");
    add(0, 1, 2, 2, "peak"); add(0, 1, -4, 2, "peak");
    add(1, 1, 4, 0, "tie"); add(0, 1, 4, 0, "tie"); add(0, 1, 4, 0, "tie");
    add(1, 1, -8, 0, "allmin"); add(0, 1, -8, 0, "allmin");
    add(1, 1, -8, 0, "min_then"); add(0, 1, -8, 0, "min_then"); add(0, 1, -3, 2, "min_then");
    add(1, 1, 2, 0, "gate"); add(0, 0, 6, 0, "gate"); add(0, 1, 5, 1, "gate");
    add(1, 1, 0, 0, "midrst"); add(0, 1, 7, 1, "midrst");
    add(1, 1, 3, 0, "midrst"); add(0, 1, 5, 1, "midrst");
    foreach (vecs[i]) begin
      if (vecs[i].rst_pre) do_reset(vecs[i].name);
      step(vecs[i].en, vecs[i].val);
      check(vecs[i].name, argmax, vecs[i].exp);
    end

    // asynchronous clear mid-cycle, no clock edge involved
    do_reset("async");
    for (int k = 0; k < 4; k++) step(1'b1, 4'(k));
    check("async_pre", argmax, 5'd3);
    @(posedge clk); #2;
    rst = 1'b0;
    #1 check("async_clear", argmax, 5'd0);
    @(negedge clk); rst = 1'b1;
    step(1'b1, -4'sd8);
    check("async_next0", argmax, 5'd0);
    step(1'b1, -4'sd7);
    check("async_next1", argmax, 5'd1);

    // random stream, includes index wrap past 32 samples
    do_reset("rand");
    for (int n = 0; n < 400; n++) begin
      bit e;
      logic signed [3:0] v;
      if ($urandom_range(0, 99) < 2) do_reset("rand");
      e = $urandom_range(0, 3) != 0;
      v = 4'($urandom);
      step(e, v);
      if (e) samples.push_back(int'(v));
      check("random", argmax, model());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
